class_vote_evaluator: RTL and testbench
=======================================

# class_vote_evaluator

- Synthesizable evaluation stage that sits behind a LUT-network classifier such as MnistLutSimple.
- Per sample, it reduces spatially multiplexed class votes (CHANNEL_NUM copies of CLASS_NUM bits) and temporally multiplexed votes (FRAME_NUM consecutive beats) into per-class scores.
- It picks the winning class by argmax, compares the winner with the label and keeps running accuracy counters.
- It replaces simulation-only scoring, so accuracy can be read on-chip.

## Interface
Parameters:
- CLASS_NUM, 10, number of classes
- CHANNEL_NUM, 1, spatial vote copies per class
- FRAME_NUM, 1, beats accumulated per sample (≥1)
- USER_WIDTH, 8, opaque sideband width
- LABEL_WIDTH, 8, label width
- COUNT_WIDTH, 32, statistic counter width
- derived: SCORE_WIDTH = clog2(CHANNEL_NUM*FRAME_NUM+1); INDEX_WIDTH = clog2(CLASS_NUM+1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cke  in  1  clock enable; when 0 all state holds
- clear  in  1  synchronous statistics clear, acts regardless of cke
- in_data  in  CLASS_NUM*CHANNEL_NUM  votes; bit j*CLASS_NUM+i is channel j, class i
- in_label  in  LABEL_WIDTH  true class
- in_user  in  USER_WIDTH  sideband
- in_last  in  1  final sample of the data set
- in_valid  in  1  beat valid (no backpressure)
- out_class  out  INDEX_WIDTH  winning class, CLASS_NUM = no winner
- out_score  out  SCORE_WIDTH  winning score
- out_label  out  LABEL_WIDTH
- out_user  out  USER_WIDTH
- out_match  out  1  out_class == out_label
- out_last  out  1
- out_valid  out  1
- stat_total  out  COUNT_WIDTH  samples counted
- stat_ok  out  COUNT_WIDTH  matches counted
- stat_done  out  1  last sample has been counted

## Operation
- **Stage A, popcount/accumulate** (on cke && in_valid):
  - cnt[i] = Σj in_data[j*CLASS_NUM+i].
  - Frame counter f runs 0..FRAME_NUM-1 and wraps.
  - At f==0: acc[i] = cnt[i], and in_label/in_user are captured.
  - Otherwise: acc[i] += cnt[i].
  - in_last is sampled only at f==FRAME_NUM-1; on earlier frames it is ignored.
  - At f==FRAME_NUM-1 the sample is complete and passes to stage B.
  - acc cannot overflow by construction of SCORE_WIDTH.
- **Stage B, argmax** (sub-module):
  - Running max starts at 0; class i wins only if acc[i] > max (strict).
  - Ties therefore go to the lowest index.
  - All scores zero: out_class = CLASS_NUM, out_score = 0, out_match = 0.
  - out_match compares zero-extended out_class with out_label.
- **Stage C, statistics** (on cke && out_valid):
  - stat_total += 1 and stat_ok += out_match; both saturate at all-ones.
  - stat_done is set when out_last is counted and stays set until reset or clear.
  - Samples keep being counted after stat_done.
- **clear:** zeroes stat_total, stat_ok and stat_done. If clear coincides with a counted sample, clear wins and that sample is not counted. clear does not touch the pipeline.
- **Reset values:** all out_* = 0, stat_* = 0, f = 0, acc = 0, valids = 0.
- **Reset mid-sample:** the partial accumulation is discarded and the next valid beat is treated as f==0.

## Timing
- Let the sample-completing beat be accepted at edge t.
  - Accumulated scores are registered at t (stage A).
  - out_* are valid after edge t+1 (stage B register): 2-cycle latency, 1 sample per FRAME_NUM beats.
  - stat_* reflect the sample after edge t+2.
- out_valid is a single-cycle pulse per sample while cke=1. With cke=0, out_valid and all state hold.
- Beats may have gaps (in_valid=0); f advances only on accepted beats.
- in_valid at full rate sustains one result per FRAME_NUM cycles.

## Structure
- **Shared package** class_vote_pkg holds:
  - the clog2 constant function;
  - the SCORE_WIDTH/INDEX_WIDTH derivation functions;
  - the NO_CLASS encoding rule (= CLASS_NUM).
- **Sub-module** class_vote_argmax, parameters CLASS_NUM, SCORE_WIDTH, INDEX_WIDTH:
  - inputs: flattened score vector plus sideband;
  - outputs: registered class/score/match;
  - also reused by future multi-class evaluation benches.
- The top level contains stage A, stage C and the sideband pipeline.

## Test plan
- CLASS_NUM=10, CHANNEL_NUM=1, FRAME_NUM=1: one-hot class 3 with label 3 → out_class=3, out_score=1, out_match=1 two cycles later; stat_total=1, stat_ok=1.
- CHANNEL_NUM=4: class 2 voted by 3 channels and class 7 by 3 channels, label 7 → tie resolves to out_class=2, out_score=3, out_match=0.
- FRAME_NUM=3, CHANNEL_NUM=2: frames give class 5 votes 2,1,2 and class 1 votes 2,2,0 → out_class=5, out_score=5. in_last asserted on frame 0 only → out_last=0.
- All-zero votes with label 0 → out_class=10, out_match=0, stat_ok unchanged.
- 100 back-to-back samples with 90 correct and in_last on the final one → stat_total=100, stat_ok=90, stat_done=1. Then clear → all stats 0.
- Reset after frame 1 of 3, then 3 fresh frames → exactly one out_valid, scores from the fresh frames only. cke low for 5 cycles mid-stream → outputs and counters frozen, no lost or duplicated samples.

Source files
------------

// File: rtl/class_vote_pkg.sv
// ---------------------------------------------------------------------------
// class_vote_pkg
// Shared constants and width helpers for the class-vote evaluation slice.
//   clog2        : ceiling log2 usable in parameter/localparam expressions
//   score_width  : bits needed to hold CHANNEL_NUM*FRAME_NUM votes
//   index_width  : bits needed to hold class indices 0..CLASS_NUM
//   no_class     : encoding of "no winner" (equal to CLASS_NUM)
//   frame_width  : bits for the frame counter (at least one bit)
// ---------------------------------------------------------------------------
package class_vote_pkg;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 32'sd0;
        remain = value - 32'sd1;
        while (remain > 32'sd0) begin
            result = result + 32'sd1;
            remain = remain >>> 1;
        end
        return result;
    endfunction

    function automatic int score_width(input int channel_num, input int frame_num);
        return clog2(channel_num * frame_num + 32'sd1);
    endfunction

    function automatic int index_width(input int class_num);
        return clog2(class_num + 32'sd1);
    endfunction

    // The index one past the last class marks "no class won"
    function automatic int no_class(input int class_num);
        return class_num;
    endfunction

    function automatic int frame_width(input int frame_num);
        return (frame_num > 32'sd1) ? clog2(frame_num) : 32'sd1;
    endfunction

endpackage

// File: rtl/class_vote_evaluator_if.sv
// ---------------------------------------------------------------------------
// class_vote_evaluator_if
// Vote stream in, per-sample result and running statistics out.
//   in_data/in_label/in_user/in_last/in_valid : vote beats (no backpressure)
//   out_class/out_score/out_label/out_user/out_match/out_last/out_valid :
//                                               one result per sample
//   stat_total/stat_ok/stat_done : accuracy counters
// master = vote source / result sink, slave = evaluator.
// ---------------------------------------------------------------------------
interface class_vote_evaluator_if #(
    parameter int CLASS_NUM   = 10,
    parameter int CHANNEL_NUM = 1,
    parameter int FRAME_NUM   = 1,
    parameter int USER_WIDTH  = 8,
    parameter int LABEL_WIDTH = 8,
    parameter int COUNT_WIDTH = 32
);
    import class_vote_pkg::*;

    localparam int SCORE_WIDTH = score_width(CHANNEL_NUM, FRAME_NUM);
    localparam int INDEX_WIDTH = index_width(CLASS_NUM);

    logic [CLASS_NUM*CHANNEL_NUM-1:0] in_data;
    logic [LABEL_WIDTH-1:0]           in_label;
    logic [USER_WIDTH-1:0]            in_user;
    logic                             in_last;
    logic                             in_valid;

    logic [INDEX_WIDTH-1:0]           out_class;
    logic [SCORE_WIDTH-1:0]           out_score;
    logic [LABEL_WIDTH-1:0]           out_label;
    logic [USER_WIDTH-1:0]            out_user;
    logic                             out_match;
    logic                             out_last;
    logic                             out_valid;

    logic [COUNT_WIDTH-1:0]           stat_total;
    logic [COUNT_WIDTH-1:0]           stat_ok;
    logic                             stat_done;

    modport master (
        output in_data, in_label, in_user, in_last, in_valid,
        input  out_class, out_score, out_label, out_user, out_match, out_last, out_valid,
        input  stat_total, stat_ok, stat_done
    );

    modport slave (
        input  in_data, in_label, in_user, in_last, in_valid,
        output out_class, out_score, out_label, out_user, out_match, out_last, out_valid,
        output stat_total, stat_ok, stat_done
    );

endinterface

// File: rtl/class_vote_argmax.sv
// ---------------------------------------------------------------------------
// class_vote_argmax
// Registered argmax over CLASS_NUM scores plus label comparison.
//   clk, reset (sync, active-high), i_cke (clock enable)
//   i_valid : scores/label are a complete sample
//   i_score : flattened scores, class i at [i*SCORE_WIDTH +: SCORE_WIDTH]
//   i_label : true class of the sample
//   o_class : winning index, CLASS_NUM when every score is zero
//   o_score : winning score
//   o_match : winner equals label (never set without a winner)
// ---------------------------------------------------------------------------
module class_vote_argmax #(
    parameter int CLASS_NUM   = 10,
    parameter int SCORE_WIDTH = 1,
    parameter int INDEX_WIDTH = 4,
    parameter int LABEL_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_cke,
    input  logic                             i_valid,
    input  logic [CLASS_NUM*SCORE_WIDTH-1:0] i_score,
    input  logic [LABEL_WIDTH-1:0]           i_label,
    output logic [INDEX_WIDTH-1:0]           o_class,
    output logic [SCORE_WIDTH-1:0]           o_score,
    output logic                             o_match
);
    import class_vote_pkg::*;

    localparam int CMP_WIDTH = (INDEX_WIDTH > LABEL_WIDTH) ? INDEX_WIDTH : LABEL_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] NO_CLASS = INDEX_WIDTH'(no_class(CLASS_NUM));

    logic [INDEX_WIDTH-1:0] w_class;
    logic [SCORE_WIDTH-1:0] w_score;
    logic                   w_take;
    logic                   w_match;

    // Strict greater-than scan from index 0: ties keep the lower index and a
    // zero score never wins, leaving NO_CLASS in place.
    always_comb begin
        w_class = NO_CLASS;
        w_score = {SCORE_WIDTH{1'b0}};
        w_take  = 1'b0;
        for (int i = 0; i < CLASS_NUM; i++) begin
            w_take  = (i_score[i*SCORE_WIDTH +: SCORE_WIDTH] > w_score);
            w_score = w_take ? i_score[i*SCORE_WIDTH +: SCORE_WIDTH] : w_score;
            w_class = w_take ? INDEX_WIDTH'(i) : w_class;
        end
        w_match = (w_class != NO_CLASS) &&
                  (CMP_WIDTH'(w_class) == CMP_WIDTH'(i_label));
    end

    // Result register, loaded once per completed sample
    always_ff @(posedge clk) begin
        if (reset) begin
            o_class <= {INDEX_WIDTH{1'b0}};
            o_score <= {SCORE_WIDTH{1'b0}};
            o_match <= 1'b0;
        end else if (i_cke && i_valid) begin
            o_class <= w_class;
            o_score <= w_score;
            o_match <= w_match;
        end
    end

endmodule

// File: rtl/class_vote_evaluator.sv
// ---------------------------------------------------------------------------
// class_vote_evaluator
// Reduces spatial (channel) and temporal (frame) class votes to per-class
// scores, picks the winner, compares it with the label and keeps running
// accuracy statistics.
//   clk   : clock
//   reset : synchronous, active-high; discards any partial sample
//   cke   : clock enable, all state holds when low
//   clear : zeroes stat_total/stat_ok/stat_done, independent of cke
//   bus   : class_vote_evaluator_if.slave (vote beats in, results out)
// Pipeline: stage A popcount/accumulate -> stage B argmax -> stage C stats.
// ---------------------------------------------------------------------------
module class_vote_evaluator #(
    parameter int CLASS_NUM   = 10,
    parameter int CHANNEL_NUM = 1,
    parameter int FRAME_NUM   = 1,
    parameter int USER_WIDTH  = 8,
    parameter int LABEL_WIDTH = 8,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic                 clear,
    class_vote_evaluator_if.slave bus
);
    import class_vote_pkg::*;

    localparam int SCORE_WIDTH = score_width(CHANNEL_NUM, FRAME_NUM);
    localparam int INDEX_WIDTH = index_width(CLASS_NUM);
    localparam int FRAME_WIDTH = frame_width(FRAME_NUM);
    localparam logic [FRAME_WIDTH-1:0] FRAME_LAST = FRAME_WIDTH'(FRAME_NUM - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = {COUNT_WIDTH{1'b1}};

    // Stage A
    logic [CLASS_NUM-1:0][SCORE_WIDTH-1:0] w_cnt;
    logic [CLASS_NUM-1:0][SCORE_WIDTH-1:0] r_acc;
    logic [FRAME_WIDTH-1:0]                r_frame;
    logic                                  w_accept;
    logic                                  w_first;
    logic                                  w_final;
    logic                                  r_a_valid;
    logic [LABEL_WIDTH-1:0]                r_a_label;
    logic [USER_WIDTH-1:0]                 r_a_user;
    logic                                  r_a_last;

    // Stage B
    logic [INDEX_WIDTH-1:0]                w_b_class;
    logic [SCORE_WIDTH-1:0]                w_b_score;
    logic                                  w_b_match;
    logic                                  r_b_valid;
    logic [LABEL_WIDTH-1:0]                r_b_label;
    logic [USER_WIDTH-1:0]                 r_b_user;
    logic                                  r_b_last;

    // Stage C
    logic [COUNT_WIDTH-1:0]                r_total;
    logic [COUNT_WIDTH-1:0]                r_ok;
    logic                                  r_done;

    assign w_accept = cke && bus.in_valid;
    assign w_first  = (r_frame == {FRAME_WIDTH{1'b0}});
    assign w_final  = (r_frame == FRAME_LAST);

    // Per-class popcount across the spatial channel copies
    always_comb begin
        w_cnt = {(CLASS_NUM*SCORE_WIDTH){1'b0}};
        for (int i = 0; i < CLASS_NUM; i++) begin
            for (int j = 0; j < CHANNEL_NUM; j++) begin
                w_cnt[i] = w_cnt[i] + SCORE_WIDTH'(bus.in_data[j*CLASS_NUM+i]);
            end
        end
    end

    // Stage A: frame counter, accumulation and sideband capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame   <= {FRAME_WIDTH{1'b0}};
            r_acc     <= {(CLASS_NUM*SCORE_WIDTH){1'b0}};
            r_a_valid <= 1'b0;
            r_a_label <= {LABEL_WIDTH{1'b0}};
            r_a_user  <= {USER_WIDTH{1'b0}};
            r_a_last  <= 1'b0;
        end else if (cke) begin
            r_a_valid <= w_accept && w_final;
            if (w_accept) begin
                for (int i = 0; i < CLASS_NUM; i++) begin
                    r_acc[i] <= w_first ? w_cnt[i] : (r_acc[i] + w_cnt[i]);
                end
                // Label/user belong to the first beat of a sample
                if (w_first) begin
                    r_a_label <= bus.in_label;
                    r_a_user  <= bus.in_user;
                end
                // in_last only counts on the sample-completing beat
                if (w_final) begin
                    r_a_last <= bus.in_last;
                    r_frame  <= {FRAME_WIDTH{1'b0}};
                end else begin
                    r_frame  <= r_frame + FRAME_WIDTH'(1'b1);
                end
            end
        end
    end

    class_vote_argmax #(
        .CLASS_NUM   (CLASS_NUM),
        .SCORE_WIDTH (SCORE_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .LABEL_WIDTH (LABEL_WIDTH)
    ) u_argmax (
        .clk     (clk),
        .reset   (reset),
        .i_cke   (cke),
        .i_valid (r_a_valid),
        .i_score (r_acc),
        .i_label (r_a_label),
        .o_class (w_b_class),
        .o_score (w_b_score),
        .o_match (w_b_match)
    );

    // Stage B sideband: travels alongside the argmax result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_valid <= 1'b0;
            r_b_label <= {LABEL_WIDTH{1'b0}};
            r_b_user  <= {USER_WIDTH{1'b0}};
            r_b_last  <= 1'b0;
        end else if (cke) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_b_label <= r_a_label;
                r_b_user  <= r_a_user;
                r_b_last  <= r_a_last;
            end
        end
    end

    // Stage C: saturating statistics; clear beats a same-cycle sample
    always_ff @(posedge clk) begin
        if (reset) begin
            r_total <= {COUNT_WIDTH{1'b0}};
            r_ok    <= {COUNT_WIDTH{1'b0}};
            r_done  <= 1'b0;
        end else if (clear) begin
            r_total <= {COUNT_WIDTH{1'b0}};
            r_ok    <= {COUNT_WIDTH{1'b0}};
            r_done  <= 1'b0;
        end else if (cke && r_b_valid) begin
            if (r_total != COUNT_MAX) begin
                r_total <= r_total + COUNT_WIDTH'(1'b1);
            end
            if (w_b_match && (r_ok != COUNT_MAX)) begin
                r_ok <= r_ok + COUNT_WIDTH'(1'b1);
            end
            if (r_b_last) begin
                r_done <= 1'b1;
            end
        end
    end

    assign bus.out_class  = w_b_class;
    assign bus.out_score  = w_b_score;
    assign bus.out_label  = r_b_label;
    assign bus.out_user   = r_b_user;
    assign bus.out_match  = w_b_match;
    assign bus.out_last   = r_b_last;
    assign bus.out_valid  = r_b_valid;
    assign bus.stat_total = r_total;
    assign bus.stat_ok    = r_ok;
    assign bus.stat_done  = r_done;

endmodule

// File: tb/tb_class_vote_evaluator.sv
// ---------------------------------------------------------------------------
// tb_class_vote_evaluator
// Directed bench for class_vote_evaluator with three configurations:
//   u_dut_a : CLASS 10, CHANNEL 1, FRAME 1
//   u_dut_b : CLASS 10, CHANNEL 4, FRAME 1
//   u_dut_c : CLASS 10, CHANNEL 2, FRAME 3
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// at the same point, i.e. they reflect the edge just passed.
// ---------------------------------------------------------------------------
module tb_class_vote_evaluator;

    logic clk = 1'b0;
    logic reset;
    logic cke;
    logic clear;

    int checks = 0;
    int errors = 0;
    int n_a_pulse = 0;
    int n_c_pulse = 0;
    int base_a;
    int base_c;
    int idx;
    int cls;

    always #5 clk = ~clk;

    class_vote_evaluator_if #(.CLASS_NUM(10), .CHANNEL_NUM(1), .FRAME_NUM(1),
        .USER_WIDTH(8), .LABEL_WIDTH(8), .COUNT_WIDTH(32)) if_a ();
    class_vote_evaluator_if #(.CLASS_NUM(10), .CHANNEL_NUM(4), .FRAME_NUM(1),
        .USER_WIDTH(8), .LABEL_WIDTH(8), .COUNT_WIDTH(32)) if_b ();
    class_vote_evaluator_if #(.CLASS_NUM(10), .CHANNEL_NUM(2), .FRAME_NUM(3),
        .USER_WIDTH(8), .LABEL_WIDTH(8), .COUNT_WIDTH(32)) if_c ();

    class_vote_evaluator #(.CLASS_NUM(10), .CHANNEL_NUM(1), .FRAME_NUM(1),
        .USER_WIDTH(8), .LABEL_WIDTH(8), .COUNT_WIDTH(32)) u_dut_a (
        .clk(clk), .reset(reset), .cke(cke), .clear(clear), .bus(if_a));
    class_vote_evaluator #(.CLASS_NUM(10), .CHANNEL_NUM(4), .FRAME_NUM(1),
        .USER_WIDTH(8), .LABEL_WIDTH(8), .COUNT_WIDTH(32)) u_dut_b (
        .clk(clk), .reset(reset), .cke(cke), .clear(clear), .bus(if_b));
    class_vote_evaluator #(.CLASS_NUM(10), .CHANNEL_NUM(2), .FRAME_NUM(3),
        .USER_WIDTH(8), .LABEL_WIDTH(8), .COUNT_WIDTH(32)) u_dut_c (
        .clk(clk), .reset(reset), .cke(cke), .clear(clear), .bus(if_c));

    // Count result pulses that the next edge will actually consume
    always @(negedge clk) begin
        if (cke && if_a.out_valid) n_a_pulse <= n_a_pulse + 1;
        if (cke && if_c.out_valid) n_c_pulse <= n_c_pulse + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cke = 1'b1; clear = 1'b0;
        if_a.in_data = 10'd0; if_a.in_label = 8'd0; if_a.in_user = 8'd0;
        if_a.in_last = 1'b0;  if_a.in_valid = 1'b0;
        if_b.in_data = 40'd0; if_b.in_label = 8'd0; if_b.in_user = 8'd0;
        if_b.in_last = 1'b0;  if_b.in_valid = 1'b0;
        if_c.in_data = 20'd0; if_c.in_label = 8'd0; if_c.in_user = 8'd0;
        if_c.in_last = 1'b0;  if_c.in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_a_class", 64'(if_a.out_class), 64'd0);
        check("rst_a_valid", 64'(if_a.out_valid), 64'd0);
        check("rst_a_total", 64'(if_a.stat_total), 64'd0);
        check("rst_a_done",  64'(if_a.stat_done), 64'd0);
        check("rst_c_score", 64'(if_c.out_score), 64'd0);

        // One-hot class 3, label 3: result two edges after acceptance
        if_a.in_data = 10'd8; if_a.in_label = 8'd3; if_a.in_user = 8'h5A;
        if_a.in_valid = 1'b1;
        tick();
        if_a.in_valid = 1'b0;
        check("a1_valid_t0", 64'(if_a.out_valid), 64'd0);
        tick();
        check("a1_valid", 64'(if_a.out_valid), 64'd1);
        check("a1_class", 64'(if_a.out_class), 64'd3);
        check("a1_score", 64'(if_a.out_score), 64'd1);
        check("a1_match", 64'(if_a.out_match), 64'd1);
        check("a1_user",  64'(if_a.out_user),  64'h5A);
        check("a1_label", 64'(if_a.out_label), 64'd3);
        tick();
        check("a1_pulse", 64'(if_a.out_valid), 64'd0);
        check("a1_total", 64'(if_a.stat_total), 64'd1);
        check("a1_ok",    64'(if_a.stat_ok),    64'd1);

        // Four channels: class 2 and class 7 both get 3 votes, tie -> 2
        if_b.in_data = 40'd0;
        if_b.in_data[2]  = 1'b1; if_b.in_data[12] = 1'b1; if_b.in_data[22] = 1'b1;
        if_b.in_data[17] = 1'b1; if_b.in_data[27] = 1'b1; if_b.in_data[37] = 1'b1;
        if_b.in_label = 8'd7; if_b.in_valid = 1'b1;
        tick();
        if_b.in_valid = 1'b0;
        tick();
        check("b_tie_class", 64'(if_b.out_class), 64'd2);
        check("b_tie_score", 64'(if_b.out_score), 64'd3);
        check("b_tie_match", 64'(if_b.out_match), 64'd0);

        // Three frames, two channels: class 5 = 2+1+2, class 1 = 2+2+0
        if_c.in_data = 20'd0;
        if_c.in_data[5] = 1'b1; if_c.in_data[15] = 1'b1;
        if_c.in_data[1] = 1'b1; if_c.in_data[11] = 1'b1;
        if_c.in_label = 8'd5; if_c.in_last = 1'b1; if_c.in_valid = 1'b1;
        tick();
        if_c.in_data = 20'd0;
        if_c.in_data[5] = 1'b1; if_c.in_data[1] = 1'b1; if_c.in_data[11] = 1'b1;
        if_c.in_label = 8'd0; if_c.in_last = 1'b0;
        tick();
        if_c.in_data = 20'd0;
        if_c.in_data[5] = 1'b1; if_c.in_data[15] = 1'b1;
        tick();
        if_c.in_valid = 1'b0;
        check("c_mid_valid", 64'(if_c.out_valid), 64'd0);
        tick();
        check("c_valid", 64'(if_c.out_valid), 64'd1);
        check("c_class", 64'(if_c.out_class), 64'd5);
        check("c_score", 64'(if_c.out_score), 64'd5);
        check("c_last",  64'(if_c.out_last),  64'd0);
        check("c_match", 64'(if_c.out_match), 64'd1);

        // All-zero votes: no winner, no match even with label 0
        if_a.in_data = 10'd0; if_a.in_label = 8'd0; if_a.in_valid = 1'b1;
        tick();
        if_a.in_valid = 1'b0;
        tick();
        check("zero_class", 64'(if_a.out_class), 64'd10);
        check("zero_score", 64'(if_a.out_score), 64'd0);
        check("zero_match", 64'(if_a.out_match), 64'd0);
        tick();
        check("zero_total", 64'(if_a.stat_total), 64'd2);
        check("zero_ok",    64'(if_a.stat_ok),    64'd1);

        // Clear before the long run
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr0_total", 64'(if_a.stat_total), 64'd0);

        // 100 back-to-back samples, the last 10 labelled wrong
        for (int k = 0; k < 100; k++) begin
            cls = k % 10;
            if_a.in_data  = 10'd1 << cls;
            if_a.in_label = (k < 90) ? 8'(cls) : 8'((cls + 1) % 10);
            if_a.in_last  = (k == 99);
            if_a.in_valid = 1'b1;
            tick();
        end
        if_a.in_valid = 1'b0; if_a.in_last = 1'b0;
        tick();
        check("run_out_last", 64'(if_a.out_last), 64'd1);
        tick();
        check("run_total", 64'(if_a.stat_total), 64'd100);
        check("run_ok",    64'(if_a.stat_ok),    64'd90);
        check("run_done",  64'(if_a.stat_done),  64'd1);

        // Clear coinciding with a counted sample: the sample is dropped
        if_a.in_data = 10'd2; if_a.in_label = 8'd1; if_a.in_valid = 1'b1;
        tick();
        if_a.in_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_total", 64'(if_a.stat_total), 64'd0);
        check("clr_ok",    64'(if_a.stat_ok),    64'd0);
        check("clr_done",  64'(if_a.stat_done),  64'd0);
        tick();
        check("clr_after_total", 64'(if_a.stat_total), 64'd0);

        // Reset after frame 1 of 3, then three fresh frames voting class 4
        if_c.in_data = 20'd0;
        if_c.in_data[0] = 1'b1; if_c.in_data[10] = 1'b1;
        if_c.in_label = 8'd0; if_c.in_valid = 1'b1;
        tick();
        if_c.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base_c = n_c_pulse;
        if_c.in_data = 20'd0; if_c.in_data[4] = 1'b1;
        if_c.in_label = 8'd4; if_c.in_valid = 1'b1;
        repeat (3) tick();
        if_c.in_valid = 1'b0;
        tick();
        check("rstmid_class", 64'(if_c.out_class), 64'd4);
        check("rstmid_score", 64'(if_c.out_score), 64'd3);
        check("rstmid_match", 64'(if_c.out_match), 64'd1);
        repeat (3) tick();
        check("rstmid_pulses", 64'(n_c_pulse - base_c), 64'd1);

        // cke low for 5 cycles mid-stream; sample s has class s+1, s2 mislabelled
        base_a = n_a_pulse;
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            cke = !((c >= 3) && (c <= 7));
            if (idx < 6) begin
                if_a.in_data  = 10'd1 << (idx + 1);
                if_a.in_label = (idx == 2) ? 8'd9 : 8'(idx + 1);
                if_a.in_valid = 1'b1;
            end else begin
                if_a.in_valid = 1'b0;
            end
            tick();
            if (cke && (idx < 6)) idx = idx + 1;
            if (c == 2) begin
                check("cke_pre_total", 64'(if_a.stat_total), 64'd1);
                check("cke_pre_class", 64'(if_a.out_class),  64'd2);
            end
            if (c == 7) begin
                check("cke_hold_total", 64'(if_a.stat_total), 64'd1);
                check("cke_hold_class", 64'(if_a.out_class),  64'd2);
                check("cke_hold_valid", 64'(if_a.out_valid),  64'd1);
            end
        end
        check("cke_total",  64'(if_a.stat_total), 64'd6);
        check("cke_ok",     64'(if_a.stat_ok),    64'd5);
        check("cke_pulses", 64'(n_a_pulse - base_a), 64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
